// File: rtl/player_input_capture_pkg.sv
// Shared definitions for the player input capture block.
//   NUM_PLAYERS / BTN_W  : controller count and buttons per controller
//   state_e              : capture FSM states
//   ID_LSB / BTN_LSB     : field offsets inside the 16-bit playerInput word
package player_input_capture_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned BTN_W       = 8;
  localparam int unsigned ID_W        = 2;

  localparam int unsigned ID_LSB  = 10;
  localparam int unsigned BTN_LSB = 0;

  typedef enum logic [1:0] {
    ARMED,
    CAPTURED,
    WAIT_RELEASE
  } state_e;

endpackage

// File: rtl/player_input_capture_input_debouncer.sv
// Two-flop synchronizer followed by a stability counter for one controller.
// The debounced byte only takes a new value after the synchronized input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   raw_i    : active-high button byte (already inverted from the pins)
//   stable_o : debounced button byte
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned WIDTH           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/player_input_capture.sv
// Captures the first of four debounced player controllers to press a button.
// The capture is held until the CPU acknowledges it, and the block re-arms
// only once every controller has been released.
//   clk             : system clock
//   rst             : asynchronous active-low reset
//   gpins           : gpio1 header, player p on [8p+7:8p], active-low; [35:32] unused
//   clear           : single-cycle acknowledge from exmem
//   playerInput     : {4'b0, id[1:0], 2'b0, buttons[7:0]} of the captured press
//   playerInputFlag : high while a capture is pending
//   firstPlayerFlag : one-hot of the captured player
module player_input_capture
  import player_input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] gpins,
  input  logic        clear,
  output logic [15:0] playerInput,
  output logic        playerInputFlag,
  output logic [3:0]  firstPlayerFlag
);

  logic [BTN_W-1:0] stable [NUM_PLAYERS];

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .WIDTH          (BTN_W)
    ) u_debouncer (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (~gpins[p*BTN_W +: BTN_W]),
      .stable_o(stable[p])
    );
  end

  logic unused_gpins;
  assign unused_gpins = ^gpins[35:32];

  // Priority select: scanning from the top down lets the lowest index win.
  logic             any_pressed;
  logic             all_released;
  logic [ID_W-1:0]  sel_id;
  logic [BTN_W-1:0] sel_btn;

  always_comb begin
    any_pressed  = 1'b0;
    all_released = 1'b1;
    sel_id       = '0;
    sel_btn      = '0;
    for (int unsigned p = NUM_PLAYERS; p > 0; p--) begin
      if (stable[p-1] != '0) begin
        any_pressed  = 1'b1;
        all_released = 1'b0;
        sel_id       = ID_W'(p - 1);
        sel_btn      = stable[p-1];
      end
    end
  end

  state_e      state_q, state_d;
  logic [15:0] pi_q, pi_d;
  logic        flag_q, flag_d;
  logic [3:0]  first_q, first_d;

  always_comb begin
    state_d = state_q;
    pi_d    = pi_q;
    flag_d  = flag_q;
    first_d = first_q;
    unique case (state_q)
      ARMED: begin
        if (any_pressed) begin
          pi_d                    = '0;
          pi_d[ID_LSB +: ID_W]    = sel_id;
          pi_d[BTN_LSB +: BTN_W]  = sel_btn;
          first_d                 = 4'b0001 << sel_id;
          flag_d                  = 1'b1;
          state_d                 = CAPTURED;
        end
      end
      CAPTURED: begin
        if (clear) begin
          pi_d    = '0;
          first_d = '0;
          flag_d  = 1'b0;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (all_released) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARMED;
      pi_q    <= '0;
      flag_q  <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      pi_q    <= pi_d;
      flag_q  <= flag_d;
      first_q <= first_d;
    end
  end

  assign playerInput     = pi_q;
  assign playerInputFlag = flag_q;
  assign firstPlayerFlag = first_q;

endmodule

// File: tb/tb_player_input_capture.sv
module tb_player_input_capture;

  localparam int unsigned DC = 4;

  logic        clk;
  logic        rst;
  logic [35:0] gpins;
  logic        clear;
  logic [15:0] playerInput;
  logic        playerInputFlag;
  logic [3:0]  firstPlayerFlag;

  int unsigned n_pass;
  int unsigned n_total;

  player_input_capture #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk            (clk),
    .rst            (rst),
    .gpins          (gpins),
    .clear          (clear),
    .playerInput    (playerInput),
    .playerInputFlag(playerInputFlag),
    .firstPlayerFlag(firstPlayerFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic tick(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] pi, input logic fl, input logic [3:0] fp);
    check({tag, ".playerInput"}, 32'(playerInput), 32'(pi));
    check({tag, ".flag"}, 32'(playerInputFlag), 32'(fl));
    check({tag, ".first"}, 32'(firstPlayerFlag), 32'(fp));
  endtask

  task automatic set_player(input int unsigned p, input logic [7:0] btn);
    gpins[p*8 +: 8] = ~btn;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    gpins   = '1;
    clear   = 1'b0;
    rst     = 1'b0;

    // Reset state
    #12;
    check_outs("reset", 16'h0000, 1'b0, 4'b0000);
    tick(2);
    rst = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      tick();
      check("idle.flag", 32'(playerInputFlag), 32'd0);
    end
    check_outs("idle", 16'h0000, 1'b0, 4'b0000);

    // clear in ARMED is ignored
    pulse_clear();
    tick(3);
    check_outs("clear_armed", 16'h0000, 1'b0, 4'b0000);

    // Bouncing player 0 never reaches the debounce threshold
    for (int unsigned i = 0; i < 20; i++) begin
      set_player(0, (i % 2 == 0) ? 8'h01 : 8'h00);
      tick(2);
      check("bounce.flag", 32'(playerInputFlag), 32'd0);
    end
    set_player(0, 8'h00);
    tick(10);
    check_outs("bounce_end", 16'h0000, 1'b0, 4'b0000);

    // Player 2 presses 0x05: flag at edge 7, not before
    set_player(2, 8'h05);
    tick(6);
    check("p2.edge6.flag", 32'(playerInputFlag), 32'd0);
    tick();
    check_outs("p2.edge7", 16'h0805, 1'b1, 4'b0100);
    // Later presses by others are ignored while captured
    set_player(1, 8'hFF);
    for (int unsigned i = 0; i < 50; i++) begin
      tick();
      check("p2.hold.pi", 32'(playerInput), 32'h0805);
    end
    check_outs("p2.hold", 16'h0805, 1'b1, 4'b0100);
    set_player(1, 8'h00);

    // Acknowledge while player 2 still holds: outputs drop, no re-trigger
    pulse_clear();
    check_outs("p2.clear", 16'h0000, 1'b0, 4'b0000);
    for (int unsigned i = 0; i < 30; i++) begin
      tick();
      check("p2.noretrig.flag", 32'(playerInputFlag), 32'd0);
    end
    set_player(2, 8'h00);
    tick(10);
    check_outs("p2.released", 16'h0000, 1'b0, 4'b0000);

    // Player 0 presses 0x02; clear asserted in the capture cycle is ignored
    set_player(0, 8'h02);
    tick(6);
    check("p0.edge6.flag", 32'(playerInputFlag), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_outs("p0.edge7", 16'h0002, 1'b1, 4'b0001);
    tick(2);
    check_outs("p0.after", 16'h0002, 1'b1, 4'b0001);
    pulse_clear();
    check_outs("p0.clear", 16'h0000, 1'b0, 4'b0000);
    set_player(0, 8'h00);
    tick(10);

    // Simultaneous presses by players 1 and 3: lowest index wins
    set_player(1, 8'h10);
    set_player(3, 8'h80);
    tick(7);
    check_outs("simul", 16'h0410, 1'b1, 4'b0010);
    pulse_clear();
    check_outs("simul.clear", 16'h0000, 1'b0, 4'b0000);
    set_player(1, 8'h00);
    set_player(3, 8'h00);
    tick(10);

    // Chord on player 3, then asynchronous reset mid-capture
    set_player(3, 8'h81);
    tick(7);
    check_outs("chord", 16'h0C81, 1'b1, 4'b1000);
    set_player(3, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("async_rst", 16'h0000, 1'b0, 4'b0000);
    tick(2);
    rst = 1'b1;
    tick(6);
    check("rearm.edge6.flag", 32'(playerInputFlag), 32'd0);
    tick();
    check_outs("rearm.edge7", 16'h0C01, 1'b1, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
